bcd_down_counter: RTL and testbench
===================================

Name: bcd_down_counter

Overview:
- Loadable, cascaded, multi-digit down-counter. It is the count-down counterpart of the team's four-bit binary up-counter.
- Each 4-bit digit counts MAX_DIGIT..0 with a borrow chain between digits.
- Emits a one-cycle terminal pulse on reaching zero. With auto-reload enabled, it acts as a programmable divide-by-N clock-enable generator; the default size divides by up to 10^7 - 1 at 10M-class clocks.
- Sits between the system clock and downstream enable-gated logic.

Parameters:
- DIGITS, 7, number of 4-bit digits; count width is 4*DIGITS.
- MAX_DIGIT, 9, highest legal digit value and the digit wrap value on borrow. 9 gives BCD; 15 gives pure binary nibbles. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; decrement only when high.
- load  input  1  synchronous load strobe; has priority over en.
- load_val  input  4*DIGITS  preset value, one digit per nibble, digit 0 in [3:0].
- auto_reload  input  1  1 = reload preset at terminal count; 0 = stop at zero.
- count  output  4*DIGITS  current counter value, registered.
- zero  output  1  high when count == 0; combinational from registered count.
- tc_pulse  output  1  registered, one-cycle pulse on terminal count.
- running  output  1  high while in state RUN.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset, immediate and asynchronous:
  - count = 0, preset register = 0, state = IDLE.
  - tc_pulse = 0, running = 0, zero = 1.
- Load sanitising: each load_val nibble greater than MAX_DIGIT is clamped to MAX_DIGIT before use.
- Load (any state): count <= clamped value, preset <= clamped value, tc_pulse <= 0.
  - Next state = RUN if the clamped value is nonzero; otherwise IDLE.
  - Load wins over en and over a simultaneous terminal event; no pulse is produced in that cycle.
- State IDLE:
  - count holds, running = 0, en ignored.
  - Only load leaves IDLE.
- State RUN, en = 0: count holds, tc_pulse <= 0.
- State RUN, en = 1, count != 1: decrement by one with a borrow chain.
  - Digit 0 always borrows.
  - Digit i decrements if all lower digits were 0 before the edge; otherwise it holds.
  - A borrowing digit at 0 wraps to MAX_DIGIT.
  - tc_pulse <= 0.
- State RUN, en = 1, count == 1 (terminal):
  - tc_pulse <= 1 for exactly one cycle.
  - If auto_reload = 1, sampled this cycle: count <= preset, stay in RUN.
  - If auto_reload = 0: count <= 0, go to IDLE.
- Auto-reload period: tc_pulse repeats every N enabled cycles for preset N. A preset of 1 pulses on every enabled cycle.
- Latency:
  - load to new count: 1 cycle.
  - Terminal enabled edge to tc_pulse high: same edge (tc_pulse is registered).
- No underflow: the counter never decrements below 0. The count == 0 with RUN combination is unreachable.
- Reset mid-count aborts immediately. No pulse is generated, and the preset is lost.
- auto_reload changes during RUN take effect only at the next terminal cycle.

Test Plan (DIGITS=2, MAX_DIGIT=9 unless noted):
- Reset asserted asynchronously mid-cycle while counting from 0x57 -> count=0x00, zero=1, running=0, tc_pulse=0 before the next clk edge.
- load_val=0x12, auto_reload=0, en=1 continuous -> count 12,11,10,09,...,01,00. Wrap 10->09 is checked. tc_pulse is high exactly once, on the edge where count becomes 00. running drops on the same edge; count stays at 00 afterwards.
- load_val=0x03, auto_reload=1, en=1 -> count 3,2,1,3,2,1,... tc_pulse on every 3rd edge, coincident with reload to 03. Check 4 periods.
- Same as above with en toggled 1,0,1,0 -> count advances only on en=1 edges; tc_pulse period = 3 enabled cycles; no pulse while en=0.
- load_val=0xAF -> clamped to 0x99. Load with value 0x00 -> IDLE, no pulse. Load asserted on the terminal cycle (count=01, en=1) -> count=load value, tc_pulse=0.
- MAX_DIGIT=15, DIGITS=1, load 0xF, auto_reload=1 -> binary sequence F..1 repeating, tc_pulse every 15 enabled cycles.

Source files
------------

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: loadable, cascaded, multi-digit down-counter.
// Each 4-bit digit counts MAX_DIGIT..0 and borrows from the digit above.
// A one-cycle tc_pulse marks terminal count. With auto_reload set, the
// preset is reloaded and the block acts as a divide-by-N enable generator.
module bcd_down_counter #(
    parameter int DIGITS    = 7,
    parameter int MAX_DIGIT = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   count,
    output logic                  zero,
    output logic                  tc_pulse,
    output logic                  running
);

    localparam int             W          = 4 * DIGITS;
    localparam logic [3:0]     MAX_NIB    = 4'(MAX_DIGIT);
    localparam logic [W-1:0]   COUNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0]   COUNT_ONE  = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_nx_s;
    logic [W-1:0]   count_r;
    logic [W-1:0]   count_nx_s;
    logic [W-1:0]   preset_r;
    logic [W-1:0]   preset_nx_s;
    logic           tc_r;
    logic           tc_nx_s;
    logic [W-1:0]   load_clamped_s;
    logic [W-1:0]   count_dec_s;
    logic           is_terminal_s;

    // Clamp every nibble of a raw preset to the legal digit range.
    function automatic logic [W-1:0] clamp_value(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > MAX_NIB) begin
                r[4*i +: 4] = MAX_NIB;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Decrement by one through the digit borrow chain. Digit 0 always
    // borrows; a higher digit borrows only when every lower digit was 0.
    // A borrowing digit at 0 wraps to MAX_DIGIT.
    function automatic logic [W-1:0] chain_decrement(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = MAX_NIB;
                    borrow      = 1'b1;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    // Datapath helpers: sanitised preset, decremented count, terminal detect.
    always_comb begin
        load_clamped_s = clamp_value(load_val);
        count_dec_s    = chain_decrement(count_r);
        is_terminal_s  = (count_r == COUNT_ONE);
    end

    // Next-state logic: load first, then the IDLE/RUN behaviour.
    always_comb begin
        state_nx_s  = state_r;
        count_nx_s  = count_r;
        preset_nx_s = preset_r;
        tc_nx_s     = 1'b0;
        if (load) begin
            // Load beats enable and any terminal event in the same cycle.
            count_nx_s  = load_clamped_s;
            preset_nx_s = load_clamped_s;
            if (load_clamped_s != COUNT_ZERO) begin
                state_nx_s = RUN;
            end else begin
                state_nx_s = IDLE;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    // Parked: count holds, enable is ignored.
                    state_nx_s = IDLE;
                end
                RUN: begin
                    if (en) begin
                        if (is_terminal_s) begin
                            tc_nx_s = 1'b1;
                            if (auto_reload) begin
                                count_nx_s = preset_r;
                                state_nx_s = RUN;
                            end else begin
                                count_nx_s = COUNT_ZERO;
                                state_nx_s = IDLE;
                            end
                        end else begin
                            count_nx_s = count_dec_s;
                        end
                    end else begin
                        count_nx_s = count_r;
                    end
                end
                default: begin
                    // Unknown state: fall back to a safe, stopped counter.
                    state_nx_s = IDLE;
                    count_nx_s = COUNT_ZERO;
                end
            endcase
        end
    end

    // State, count, preset and pulse registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            count_r  <= COUNT_ZERO;
            preset_r <= COUNT_ZERO;
            tc_r     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            count_r  <= count_nx_s;
            preset_r <= preset_nx_s;
            tc_r     <= tc_nx_s;
        end
    end

    assign count    = count_r;
    assign zero     = (count_r == COUNT_ZERO);
    assign tc_pulse = tc_r;
    assign running  = (state_r == RUN);

endmodule

// File: tb/tb_bcd_down_counter.sv
// Self-checking bench for bcd_down_counter: a 2-digit BCD instance and a
// 1-digit binary-nibble instance, each checked every cycle against an
// integer-valued behavioural model (count held as a plain number in radix
// MAX_DIGIT+1), plus literal expectations for the directed scenarios.
module tb_bcd_down_counter;

    logic clk = 1'b0;
    logic rst;

    logic       a_en, a_load, a_ar;
    logic [7:0] a_load_val, a_count;
    logic       a_zero, a_tc, a_run;

    logic       b_en, b_load, b_ar;
    logic [3:0] b_load_val, b_count;
    logic       b_zero, b_tc, b_run;

    int checks = 0;
    int errors = 0;

    bcd_down_counter #(.DIGITS(2), .MAX_DIGIT(9)) dut (
        .clk(clk), .rst(rst), .en(a_en), .load(a_load), .load_val(a_load_val),
        .auto_reload(a_ar), .count(a_count), .zero(a_zero), .tc_pulse(a_tc),
        .running(a_run)
    );

    bcd_down_counter #(.DIGITS(1), .MAX_DIGIT(15)) dut_bin (
        .clk(clk), .rst(rst), .en(b_en), .load(b_load), .load_val(b_load_val),
        .auto_reload(b_ar), .count(b_count), .zero(b_zero), .tc_pulse(b_tc),
        .running(b_run)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int preset;
        bit run;
        bit tc;
    } mstate_t;

    mstate_t ma, mb;

    // Clamp each digit to maxd and return the value as a plain integer.
    function automatic int clamp_to_int(input logic [31:0] v, input int digits, input int maxd);
        int n, mult, d;
        n = 0; mult = 1;
        for (int i = 0; i < digits; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > maxd) d = maxd;
            n += d * mult;
            mult *= (maxd + 1);
        end
        return n;
    endfunction

    // Render an integer as packed digits in radix maxd+1.
    function automatic logic [31:0] int_to_vec(input int n, input int digits, input int maxd);
        logic [31:0] v;
        int x;
        v = 32'd0; x = n;
        for (int i = 0; i < digits; i++) begin
            v[4*i +: 4] = 4'(x % (maxd + 1));
            x = x / (maxd + 1);
        end
        return v;
    endfunction

    // One clock edge of the behavioural model.
    function automatic mstate_t mstep(input mstate_t s, input bit ld, input int ld_n,
                                      input bit en, input bit ar);
        mstate_t r;
        r = s;
        r.tc = 1'b0;
        if (ld) begin
            r.n = ld_n; r.preset = ld_n; r.run = (ld_n != 0);
        end else if (s.run && en) begin
            if (s.n == 1) begin
                r.tc = 1'b1;
                if (ar) r.n = s.preset;
                else begin r.n = 0; r.run = 1'b0; end
            end else begin
                r.n = s.n - 1;
            end
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model advances on every edge; reset clears it immediately.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma = '{0, 0, 1'b0, 1'b0};
            mb = '{0, 0, 1'b0, 1'b0};
        end else begin
            ma = mstep(ma, a_load, clamp_to_int(32'(a_load_val), 2, 9), a_en, a_ar);
            mb = mstep(mb, b_load, clamp_to_int(32'(b_load_val), 1, 15), b_en, b_ar);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("a_count",   32'(a_count), int_to_vec(ma.n, 2, 9));
            chk("a_zero",    32'(a_zero),  32'(ma.n == 0));
            chk("a_tc",      32'(a_tc),    32'(ma.tc));
            chk("a_running", 32'(a_run),   32'(ma.run));
            chk("b_count",   32'(b_count), int_to_vec(mb.n, 1, 15));
            chk("b_zero",    32'(b_zero),  32'(mb.n == 0));
            chk("b_tc",      32'(b_tc),    32'(mb.tc));
            chk("b_running", 32'(b_run),   32'(mb.run));
        end
    end

    logic [7:0] seq [0:13];
    int         pulses;
    logic       run12;

    initial begin
        rst = 1'b0;
        a_en = 1'b0; a_load = 1'b0; a_ar = 1'b0; a_load_val = 8'h00;
        b_en = 1'b0; b_load = 1'b0; b_ar = 1'b0; b_load_val = 4'h0;
        #1 rst = 1'b1;
        #1;
        chk("rst_a_count", 32'(a_count), 32'h0);
        chk("rst_a_zero",  32'(a_zero),  32'h1);
        chk("rst_a_run",   32'(a_run),   32'h0);
        chk("rst_a_tc",    32'(a_tc),    32'h0);
        chk("rst_b_count", 32'(b_count), 32'h0);
        chk("rst_b_zero",  32'(b_zero),  32'h1);
        tick();
        rst = 1'b0;

        // Count 12 down to 00 with no reload.
        a_load = 1'b1; a_load_val = 8'h12; a_ar = 1'b0; a_en = 1'b1;
        tick();
        a_load = 1'b0;
        pulses = 0; run12 = 1'b1;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            seq[k] = a_count;
            pulses += int'(a_tc);
            if (k == 12) run12 = a_run;
        end
        chk("seq_start_12", 32'(seq[0]),  32'h12);
        chk("seq_10",       32'(seq[2]),  32'h10);
        chk("seq_wrap_09",  32'(seq[3]),  32'h09);
        chk("seq_reach_00", 32'(seq[12]), 32'h00);
        chk("seq_hold_00",  32'(seq[13]), 32'h00);
        chk("pulse_once",   32'(pulses),  32'd1);
        chk("running_drop", 32'(run12),   32'h0);

        // Asynchronous reset mid-count from 57.
        a_load = 1'b1; a_load_val = 8'h57; a_en = 1'b1;
        tick();
        a_load = 1'b0;
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        chk("midrst_count", 32'(a_count), 32'h00);
        chk("midrst_zero",  32'(a_zero),  32'h1);
        chk("midrst_run",   32'(a_run),   32'h0);
        chk("midrst_tc",    32'(a_tc),    32'h0);
        tick();
        rst = 1'b0;

        // Auto-reload period 3, continuous enable: four periods.
        a_load = 1'b1; a_load_val = 8'h03; a_ar = 1'b1; a_en = 1'b1;
        tick();
        a_load = 1'b0;
        pulses = 0;
        repeat (13) begin
            @(negedge clk);
            pulses += int'(a_tc);
        end
        chk("reload_pulses", 32'(pulses), 32'd4);
        chk("reload_value",  32'(a_count), 32'h03);

        // Auto-reload with enable toggling: 9 enabled edges give 3 pulses.
        a_load = 1'b1; a_load_val = 8'h03; a_en = 1'b1;
        tick();
        a_load = 1'b0;
        pulses = 0;
        for (int k = 0; k < 18; k++) begin
            a_en = (k % 2 == 0);
            tick();
            pulses += int'(a_tc);
        end
        chk("toggle_pulses", 32'(pulses), 32'd3);

        // Clamping and load of zero.
        a_load = 1'b1; a_load_val = 8'hAF;
        tick();
        chk("clamp_99",     32'(a_count), 32'h99);
        chk("clamp_run",    32'(a_run),   32'h1);
        a_load_val = 8'h00;
        tick();
        chk("load0_count",  32'(a_count), 32'h00);
        chk("load0_run",    32'(a_run),   32'h0);
        chk("load0_tc",     32'(a_tc),    32'h0);

        // Load on the terminal cycle wins and suppresses the pulse.
        a_load_val = 8'h02; a_ar = 1'b0; a_en = 1'b1;
        tick();
        a_load = 1'b0;
        tick();
        chk("pre_term_01",  32'(a_count), 32'h01);
        a_load = 1'b1; a_load_val = 8'h45;
        tick();
        a_load = 1'b0;
        chk("term_load_45", 32'(a_count), 32'h45);
        chk("term_load_tc", 32'(a_tc),    32'h0);

        // Binary nibble instance: F..1 repeating, pulse every 15 enables.
        b_load = 1'b1; b_load_val = 4'hF; b_ar = 1'b1; b_en = 1'b1;
        tick();
        b_load = 1'b0;
        chk("bin_load_f", 32'(b_count), 32'hF);
        pulses = 0;
        repeat (45) begin
            tick();
            pulses += int'(b_tc);
        end
        chk("bin_pulses", 32'(pulses), 32'd3);
        chk("bin_reload", 32'(b_count), 32'hF);

        // Randomised traffic on both instances, checked by the model.
        for (int k = 0; k < 500; k++) begin
            a_load     = ($urandom_range(0, 15) == 0);
            a_load_val = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(0, 5));
            a_en       = ($urandom_range(0, 3) != 0);
            a_ar       = 1'($urandom_range(0, 1));
            b_load     = ($urandom_range(0, 15) == 0);
            b_load_val = 4'($urandom);
            b_en       = ($urandom_range(0, 3) != 0);
            b_ar       = 1'($urandom_range(0, 1));
            tick();
        end

        a_load = 1'b0; b_load = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
